// File: rtl/sat_pkg.sv
// Shared types and clamp helpers for the saturating
// scale-add/accumulate datapath.
package sat_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  function automatic logic [31:0] sat_max(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_clamp(
    input logic [31:0] value,
    input int unsigned w
  );
    return (value > sat_max(w)) ? sat_max(w) : value;
  endfunction

endpackage

// File: rtl/sat_pipe_stage.sv
// One valid/ready register slice; accepts whenever
// empty or its current beat is being taken.
module sat_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Load a new beat (or go empty) whenever the slot frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/sat_scale_acc.sv
// Two-stage saturating y = sat(a + (b << SHIFT)) with
// optional accumulation and a sticky saturation flag.
module sat_scale_acc
  import sat_pkg::*;
#(
  parameter int unsigned W     = 5,
  parameter int unsigned SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_acc,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_sat,
  output logic         sat_sticky
);

  localparam int unsigned W1 = W + SHIFT + 1;
  localparam int unsigned W2 = W + SHIFT + 2;
  localparam logic [W2-1:0] RMAX = W2'(sat_max(W));

  logic [W1-1:0] sum1;
  logic [W1:0]   s1_in;
  logic [W1:0]   s1_data;
  logic          s1_valid;
  logic          s2_ready;
  mode_e         s1_mode;
  logic [W1-1:0] s1_sum;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_eff;
  logic [W2-1:0] r;
  logic          r_sat;
  logic [W-1:0]  r_y;
  logic          enter;

  assign sum1  = W1'(in_a) + (W1'(in_b) << SHIFT);
  assign s1_in = {in_acc, sum1};

  sat_pipe_stage #(
    .WIDTH (W1 + 1)
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_mode = mode_e'(s1_data[W1]);
  assign s1_sum  = s1_data[W1-1:0];
  assign enter   = s1_valid && s2_ready;

  // Clear takes effect before a coincident beat reads acc.
  always_comb begin
    acc_eff = acc_clr ? '0 : acc;
    r       = W2'(s1_sum);
    if (s1_mode == MODE_ACC) begin
      r = W2'(acc_eff) + W2'(s1_sum);
    end
    r_sat = r > RMAX;
    r_y   = W'(sat_clamp(32'(r), W));
  end

  sat_pipe_stage #(
    .WIDTH (W + 1)
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({r_sat, r_y}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_sat, out_y})
  );

  // Accumulator and sticky flag update as a beat enters S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (enter && s1_mode == MODE_ACC) begin
        acc <= r_y;
      end else begin
        acc <= acc_eff;
      end
      sat_sticky <= (sat_sticky && !acc_clr)
                    || (enter && r_sat);
    end
  end

endmodule

// File: tb/tb_sat_scale_acc.sv
// Randomised and directed bench for sat_scale_acc
// against an arithmetic reference model.
module tb_sat_scale_acc;

  localparam int W     = 5;
  localparam int SHIFT = 1;
  localparam int MAXV  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_acc;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_sat;
  logic         sat_sticky;

  sat_scale_acc #(
    .W     (W),
    .SHIFT (SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_acc     (in_acc),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int sat;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_acc    = 0;
  int   m_sticky = 0;
  int   cyc_n    = 0;
  int   last_y   = 0;
  int   last_sat = 0;
  int   last_lat = 0;
  bit   accepted = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(
    input int a,
    input int b,
    input int mode
  );
    exp_t e;
    int   r;
    r = a + b * (2 ** SHIFT);
    if (mode != 0) r = r + m_acc;
    e.sat = (r > MAXV) ? 1 : 0;
    e.y   = (r > MAXV) ? MAXV : r;
    e.t   = cyc_n;
    if (mode != 0) m_acc = e.y;
    if (e.sat != 0) m_sticky = 1;
    return e;
  endfunction

  // Evaluate one cycle: inputs already driven after a negedge.
  task automatic cyc();
    exp_t e;
    #1;
    accepted = 0;
    chk("in_ready", 32'(in_ready),
        32'((exp_q.size() < 2) || out_ready));
    if (exp_q.size() == 0) begin
      chk("idle_valid", 32'(out_valid), 0);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_y", 32'(out_y), e.y);
        chk("out_sat", 32'(out_sat), e.sat);
        last_y   = int'(out_y);
        last_sat = int'(out_sat);
        last_lat = cyc_n - e.t;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(int'(in_a), int'(in_b),
                            int'(in_acc)));
      accepted = 1;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic send(input int a, input int b, input int m);
    int k;
    in_a     = W'(a);
    in_b     = W'(b);
    in_acc   = m[0];
    in_valid = 1'b1;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!accepted && k < 50);
    if (!accepted) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      cyc();
      k++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic clear_cycle();
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    cyc();
    acc_clr  = 1'b0;
    m_acc    = 0;
    m_sticky = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int nxt;
    int k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_acc    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_sticky", 32'(sat_sticky), 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(3, 4, 0);
    drain();
    chk("add_y", last_y, 11);
    chk("add_sat", last_sat, 0);
    chk("latency", last_lat, 2);

    send(20, 10, 0);
    drain();
    chk("sat_y", last_y, 31);
    chk("sat_flag", last_sat, 1);
    chk("sticky_set", 32'(sat_sticky), 1);
    send(31, 0, 0);
    drain();
    chk("max_y", last_y, 31);
    chk("max_nosat", last_sat, 0);
    chk("sticky_hold", 32'(sat_sticky), 1);

    send(3, 4, 1);
    send(3, 4, 1);
    send(3, 4, 1);
    drain();
    chk("acc3_y", last_y, 31);
    chk("acc3_sat", last_sat, 1);
    send(3, 4, 1);
    drain();
    chk("acc4_y", last_y, 31);
    chk("acc4_sat", last_sat, 1);

    clear_cycle();
    chk("clr_sticky", 32'(sat_sticky), 0);
    send(1, 0, 1);
    drain();
    chk("clr_acc_y", last_y, 1);
    chk("clr_acc_sticky", 32'(sat_sticky), 0);
    m_acc = 0;
    send(2, 1, 1);
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    cyc();
    acc_clr  = 1'b0;
    drain();
    chk("clr_coinc_y", last_y, 4);

    nxt = 0;
    k = 0;
    while ((nxt < 8 || exp_q.size() > 0) && k < 100) begin
      out_ready = pat[k % 4];
      if (nxt < 8) begin
        in_valid = 1'b1;
        in_a     = W'(nxt);
        in_b     = '0;
        in_acc   = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (accepted) nxt++;
      k++;
    end
    chk("bp_sent", nxt, 8);
    chk("bp_empty", exp_q.size(), 0);
    chk("bp_last", last_y, 7);
    drain();

    for (int blk = 0; blk < 8; blk++) begin
      in_valid = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (!in_valid || accepted) begin
          in_valid = ($urandom % 4) != 0;
          in_a     = W'($urandom);
          in_b     = W'($urandom);
          in_acc   = ($urandom % 3) == 0;
        end
        out_ready = ($urandom % 3) != 0;
        cyc();
      end
      drain();
      chk("rnd_sticky", 32'(sat_sticky), m_sticky);
      clear_cycle();
    end

    out_ready = 1'b0;
    send(7, 1, 1);
    send(9, 2, 1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_sticky", 32'(sat_sticky), 0);
    exp_q.delete();
    m_acc    = 0;
    m_sticky = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(5, 0, 1);
    drain();
    chk("post_rst_acc", last_y, 5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_scale_acc.md
Name: sat_scale_acc

Overview:
- Parametrised, pipelined successor to the team's combinational saturating scale-add `y = sat(a + (b << SHIFT))`.
- Adds a valid/ready stream interface, a 2-stage pipeline, an accumulate mode with synchronous clear, and a sticky saturation flag.
- Sits between operand producers and downstream consumers in the datapath.

Parameters:
- W, 5, operand/result width in bits (unsigned)
- SHIFT, 1, left-shift applied to b (scale factor 2^SHIFT), range 0..4

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_acc  in  1  per-beat mode: 0 = scale-add, 1 = accumulate
- acc_clr  in  1  synchronous clear of accumulator and sat_sticky
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_y  out  W  saturated result
- out_sat  out  1  this beat saturated
- sat_sticky  out  1  any beat saturated since reset/clear

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state clears immediately on assertion.
- Reset values: in_ready=1, out_valid=0, out_y=0, out_sat=0, sat_sticky=0, accumulator=0, both stage valids=0.
- Handshakes:
  - A beat transfers on valid&&ready at a rising edge.
  - A valid signal, once asserted, holds with stable data until ready (applies to in_* from the source and out_* from this block).
- Pipeline:
  - S1 registers `sum1 = in_a + (in_b << SHIFT)`, computed at width W+SHIFT+1 (no overflow), plus the mode bit.
  - S2 computes the final result and drives out_*.
  - Latency with no stall: 2 cycles, input accept to out_valid.
  - Throughput: 1 beat/cycle.
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no internal skid buffer).
  - No beat is lost or duplicated under any out_ready pattern.
- Mode 0: `r = sum1`; `out_y = (r > 2^W-1) ? 2^W-1 : r[W-1:0]`; out_sat=1 iff clamped. The accumulator is unchanged.
- Mode 1: `r = acc + sum1`, computed at width W+SHIFT+2; out_y is the clamped r; out_sat=1 iff clamped. The accumulator takes the clamped value when the beat enters S2.
- Accumulate ordering:
  - Back-to-back mode-1 beats see each other's updates.
  - The accumulator value used is the one after all earlier beats have entered S2.
- sat_sticky: set when any beat with out_sat=1 enters S2; cleared only by reset or acc_clr.
- acc_clr:
  - On a cycle with acc_clr=1, accumulator and sat_sticky become 0.
  - If a mode-1 beat enters S2 in the same cycle, it uses acc=0 (clear first), and its result and saturation are then applied.
  - Beats already in flight are not flushed.
- Boundaries:
  - a = 2^W-1, b = 0 gives exactly 2^W-1 with out_sat=0.
  - A result of exactly 2^W-1 is not saturation.
  - The accumulator sticks at max and is never wrapped.
- Reset mid-operation: in-flight beats are discarded, and out_valid drops asynchronously.

Decomposition:
- Package sat_pkg holds:
  - `localparam function sat_max(W)`
  - typedef for the mode enum {MODE_ADD, MODE_ACC}
  - the generic clamp function `sat_clamp(value, W)`
- One natural sub-module, `sat_pipe_stage`: a valid/ready register slice parametrised on payload width, instantiated twice.
- Arithmetic stays in the top.

Test Plan (W=5, SHIFT=1, out_ready=1 unless stated):
- Mode 0, a=3, b=4 → out_y=11, out_sat=0, out_valid exactly 2 cycles after accept.
- Mode 0, a=20, b=10 → out_y=31, out_sat=1, sat_sticky=1 on the following cycle. Then a=31, b=0 → out_y=31, out_sat=0, and sat_sticky stays 1.
- Mode 1, three back-to-back beats of a=3, b=4 → out_y=11, 22, 31, with out_sat=0, 0, 1. A fourth identical beat → 31, out_sat=1.
- acc_clr pulse, then mode 1 with a=1, b=0 → out_y=1, sat_sticky=0. Clear coincident with a mode-1 beat entering S2 (a=2, b=1) → out_y=4.
- Backpressure: stream 8 mode-0 beats (a=i, b=0) while out_ready toggles 1,0,0,1,… → outputs in order 0..7, no drops or duplicates, in_ready=0 whenever both stages are full and out_ready=0.
- Assert rst_n low with both stages full → out_valid=0, in_ready=1 immediately. After release, mode 1 with a=5, b=0 → out_y=5 (accumulator cleared).
